stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Timekeeping stage directly downstream of the stopwatch clock divider.
- Consumes the divider's 1 ms terminal-count tick and counts elapsed time as BCD MM:SS.cc.
- Runs a start/stop/lap/clear control FSM from single-cycle button pulses.
- Drives the divider's enable and presents six BCD digits to the display multiplexer, which is clocked by the divider's refresh tick.

Parameters:
- TICKS_PER_CS, 10, number of 1 ms ticks per centisecond; legal range 2..15.
- MAX_MIN, 59, highest minutes value before wrap; legal range 1..99.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset; all state clears while low
- tick_1ms  in  1  one-cycle pulse every 1 ms, from the divider terminal count
- start_stop  in  1  debounced one-cycle pulse
- lap_clr  in  1  debounced one-cycle pulse
- div_en  out  1  enable to the clock divider; high in RUN and LAP
- digits  out  24  BCD {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, displayed value
- running  out  1  high in RUN or LAP
- lap_active  out  1  high in LAP
- ovf  out  1  one-cycle pulse on wrap from MAX_MIN:59.99 to 00:00.00

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - Sub-tick counter, time counters and lap snapshot cleared.
  - digits = 24'h000000; div_en, running, lap_active and ovf = 0.
- All outputs are registered.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: start_stop -> RUN; lap_clr ignored.
  - RUN: start_stop -> PAUSE; lap_clr -> LAP and capture snapshot.
  - LAP: start_stop -> PAUSE and release snapshot; lap_clr -> RUN and release snapshot.
  - PAUSE: start_stop -> RUN; lap_clr -> IDLE and clear all counters on the same edge.
  - start_stop and lap_clr in the same cycle: start_stop wins, lap_clr discarded.
- Counting:
  - tick_1ms is qualified by the current (pre-edge) state. It counts only when state is RUN or LAP; otherwise it is ignored.
  - A tick in the same cycle as a RUN->PAUSE transition is counted.
  - Sub-tick counter runs 0..TICKS_PER_CS-1. A tick at the terminal value resets it to 0 and carries into cs.
  - Carry chain:
    - cs_u 0..9, then cs_t 0..9.
    - sec_u 0..9, then sec_t 0..5.
    - Minutes as BCD 00..MAX_MIN.
    - Each digit wraps to 0 and carries to the next digit in the same cycle.
  - Full wrap: MAX_MIN:59.99 plus a carry gives 00:00.00, and ovf pulses on that edge. Counting continues after the wrap.
- Display:
  - digits follows the live counter, one cycle behind, in IDLE/RUN/PAUSE.
  - In LAP, digits shows the snapshot. The snapshot is the live counter value before the edge on which lap_clr was sampled, i.e. any tick in that cycle is excluded from the snapshot.
  - On release from LAP, digits shows the live value on the next cycle.
- Timing: div_en, running and lap_active change one cycle after the accepted pulse.
- div_en falls on entry to PAUSE/IDLE, so the divider stops counting. The sub-tick counter is retained across pause, giving resolution loss below 1 ms only.
- Reset asserted mid-count overrides everything immediately. Counting resumes only after reset is released and start_stop is received.

Optional Feature:
- Macro STOPWATCH_LAP_EN.
- Defined: LAP state, snapshot register and lap_active behave as specified.
- Undefined:
  - No LAP state and no snapshot register.
  - lap_active is tied to 0.
  - lap_clr in RUN is ignored; lap_clr acts only as clear in PAUSE.
  - digits always follows the live counter.

Test Plan:
- Reset low, then high, then start_stop, then 1000 tick_1ms pulses -> digits = 24'h000100 (00:01.00), running = 1, div_en = 1.
- In RUN at 00:05.37, lap_clr, then 230 more ticks -> digits holds 24'h000537 and lap_active = 1; a second lap_clr -> digits = 24'h000560 next cycle.
- Preload to 59:59.99 with the sub-tick at 9, then one tick -> digits = 24'h000000 and ovf high exactly one cycle.
- start_stop and lap_clr in the same cycle while in RUN -> state = PAUSE and no snapshot taken; then lap_clr -> digits = 24'h000000 and state = IDLE.
- Tick coincident with start_stop in RUN at sub-tick 9, cs = 12 -> paused value shows cs = 13; ticks while in PAUSE -> no change; div_en = 0.
- Reset pulsed low mid-count at 00:42.00 -> all outputs are 0 asynchronously, before the next clk edge; state = IDLE after release.

Source files
------------

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: counts 1 ms ticks into BCD MM:SS.cc under a start/stop/lap/clear FSM.
// Optional lap snapshot is compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_core #(
  parameter int TICKS_PER_CS = 10,
  parameter int MAX_MIN      = 59
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1ms,
  input  logic        start_stop,
  input  logic        lap_clr,
  output logic        div_en,
  output logic [23:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        ovf
);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
`endif

  localparam logic [3:0] SUB_MAX = 4'(TICKS_PER_CS - 1);
  localparam logic [3:0] MAX_T   = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_U   = 4'(MAX_MIN % 10);
  // Terminal values for cs_u, cs_t, sec_u, sec_t (index 0..3)
  localparam logic [3:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd9, 4'd9};

  state_t          state, nxt;
  logic [3:0]      sub_q, sub_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic [23:0]     disp_d;
  logic            clr, cnt, wrap, carry, run_nxt;

  always_comb begin
    nxt = state;
    clr = 1'b0;
    unique case (state)
      S_IDLE:  if (start_stop) nxt = S_RUN;
`ifdef STOPWATCH_LAP_EN
      S_RUN:   if (start_stop) nxt = S_PAUSE;
               else if (lap_clr) nxt = S_LAP;
      S_LAP:   if (start_stop) nxt = S_PAUSE;
               else if (lap_clr) nxt = S_RUN;
`else
      S_RUN:   if (start_stop) nxt = S_PAUSE;
`endif
      S_PAUSE: if (start_stop) nxt = S_RUN;
               else if (lap_clr) begin
                 nxt = S_IDLE;
                 clr = 1'b1;
               end
      default: nxt = S_IDLE;
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  assign cnt     = tick_1ms && (state == S_RUN || state == S_LAP);
  assign run_nxt = (nxt == S_RUN) || (nxt == S_LAP);
`else
  assign cnt     = tick_1ms && (state == S_RUN);
  assign run_nxt = (nxt == S_RUN);
`endif

  // Sub-tick prescale then ripple carry through the BCD digits in one cycle
  always_comb begin
    sub_d = sub_q;
    dig_d = dig_q;
    wrap  = 1'b0;
    carry = 1'b0;
    if (clr) begin
      sub_d = '0;
      dig_d = '0;
    end else if (cnt) begin
      if (sub_q == SUB_MAX) begin
        sub_d = '0;
        carry = 1'b1;
      end else begin
        sub_d = sub_q + 4'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (dig_q[i] == DIG_MAX[i]) dig_d[i] = '0;
          else begin
            dig_d[i] = dig_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
      if (carry) begin
        if (dig_q[5] == MAX_T && dig_q[4] == MAX_U) begin
          dig_d[5] = '0;
          dig_d[4] = '0;
          wrap     = 1'b1;
        end else if (dig_q[4] == 4'd9) begin
          dig_d[4] = '0;
          dig_d[5] = dig_q[5] + 4'd1;
        end else begin
          dig_d[4] = dig_q[4] + 4'd1;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [23:0] snap_q;

  // Snapshot holds the pre-edge live value, so a coincident tick is excluded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                snap_q <= '0;
    else if (state == S_RUN && nxt == S_LAP)   snap_q <= dig_q;
  end

  assign disp_d = (state == S_LAP && nxt == S_LAP) ? snap_q : dig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lap_active <= 1'b0;
    else        lap_active <= (nxt == S_LAP);
  end
`else
  assign disp_d     = dig_q;
  assign lap_active = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      sub_q   <= '0;
      dig_q   <= '0;
      digits  <= '0;
      div_en  <= 1'b0;
      running <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= nxt;
      sub_q   <= sub_d;
      dig_q   <= dig_d;
      digits  <= disp_d;
      div_en  <= run_nxt;
      running <= run_nxt;
      ovf     <= wrap;
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomized and directed bench for stopwatch_core against a centisecond-count reference model.
module tb_stopwatch_core;
  localparam int TPC       = 3;
  localparam int MM        = 1;
  localparam int PERIOD_CS = (MM + 1) * 6000;
  localparam int PERIOD_T  = PERIOD_CS * TPC;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0;
  logic        tick_1ms = 1'b0, start_stop = 1'b0, lap_clr = 1'b0;
  logic        div_en, running, lap_active, ovf;
  logic [23:0] digits;

  stopwatch_core #(.TICKS_PER_CS(TPC), .MAX_MIN(MM)) dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start_stop(start_stop),
    .lap_clr(lap_clr), .div_en(div_en), .digits(digits), .running(running),
    .lap_active(lap_active), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: 0 idle, 1 run, 2 pause, 3 lap; time kept as total ticks modulo full period
  int          m_state, m_ticks, m_snap;
  logic [23:0] e_digits;
  logic        e_ovf, e_run, e_lap;

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_ticks = 0; m_snap = 0;
    e_digits = '0; e_ovf = 0; e_run = 0; e_lap = 0;
  endtask

  task automatic step(input bit t, input bit ss, input bit lc);
    int pre_cs, nst;
    tick_1ms = t; start_stop = ss; lap_clr = lc;
    @(posedge clk);
    pre_cs = m_ticks / TPC;
    nst    = m_state;
    e_ovf  = 1'b0;
    if (t && (m_state == 1 || m_state == 3)) begin
      m_ticks++;
      if (m_ticks == PERIOD_T) begin
        m_ticks = 0;
        e_ovf   = 1'b1;
      end
    end
    if (ss) nst = (m_state == 0 || m_state == 2) ? 1 : 2;
    else if (lc) begin
      case (m_state)
        1: if (LAP_EN) begin nst = 3; m_snap = pre_cs; end
        3: nst = 1;
        2: begin nst = 0; m_ticks = 0; end
        default: ;
      endcase
    end
    e_digits = (m_state == 3 && nst == 3) ? to_bcd(m_snap) : to_bcd(pre_cs);
    m_state  = nst;
    e_run    = (nst == 1 || nst == 3);
    e_lap    = (nst == 3);
    #1;
    tick_1ms = 1'b0; start_stop = 1'b0; lap_clr = 1'b0;
  endtask

  task automatic do_reset();
    tick_1ms = 0; start_stop = 0; lap_clr = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (digits !== 24'h0) begin failures++; $display("FAIL reset_digits got=%h exp=000000", digits); end
    checks++; if (div_en !== 1'b0) begin failures++; $display("FAIL reset_div_en got=%b exp=0", div_en); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (lap_active !== 1'b0) begin failures++; $display("FAIL reset_lap got=%b exp=0", lap_active); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    @(posedge clk); #2;
    reset = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++; if (running !== 1'b0 || digits !== 24'h0) begin failures++; $display("FAIL idle_ignore got=%b/%h exp=0/000000", running, digits); end
  endtask

  task automatic test_count_1s();
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    run_ticks(TPC * 100);
    step(1'b0, 1'b0, 1'b0);
    checks++; if (digits !== 24'h000100) begin failures++; $display("FAIL count_1s got=%h exp=000100", digits); end
    checks++; if (running !== 1'b1 || div_en !== 1'b1) begin failures++; $display("FAIL count_run got=%b%b exp=11", running, div_en); end
  endtask

  task automatic test_lap();
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    run_ticks(TPC * 537);
    step(1'b1, 1'b0, 1'b1);
    run_ticks(TPC * 23 - 1);
    step(1'b0, 1'b0, 1'b0);
    if (LAP_EN) begin
      checks++; if (digits !== 24'h000537) begin failures++; $display("FAIL lap_hold got=%h exp=000537", digits); end
      checks++; if (lap_active !== 1'b1 || running !== 1'b1) begin failures++; $display("FAIL lap_flags got=%b%b exp=11", lap_active, running); end
      step(1'b0, 1'b0, 1'b1);
      checks++; if (digits !== 24'h000560) begin failures++; $display("FAIL lap_release got=%h exp=000560", digits); end
      checks++; if (lap_active !== 1'b0 || running !== 1'b1) begin failures++; $display("FAIL lap_release_flags got=%b%b exp=01", lap_active, running); end
    end else begin
      checks++; if (digits !== 24'h000560) begin failures++; $display("FAIL nolap_live got=%h exp=000560", digits); end
      checks++; if (lap_active !== 1'b0 || running !== 1'b1) begin failures++; $display("FAIL nolap_flags got=%b%b exp=01", lap_active, running); end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    run_ticks(50);
    step(1'b0, 1'b1, 1'b1);
    checks++; if (running !== 1'b0 || div_en !== 1'b0 || lap_active !== 1'b0) begin failures++; $display("FAIL same_pause got=%b%b%b exp=000", running, div_en, lap_active); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (digits !== e_digits || digits === 24'h0) begin failures++; $display("FAIL same_hold got=%h exp=%h", digits, e_digits); end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checks++; if (digits !== 24'h0) begin failures++; $display("FAIL clear_digits got=%h exp=000000", digits); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL clear_idle_restart got=%b exp=1", running); end
  endtask

  task automatic test_tick_pause();
    int bad;
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    run_ticks(TPC * 12 + TPC - 1);
    step(1'b1, 1'b1, 1'b0);
    checks++; if (div_en !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL pause_flags got=%b%b exp=00", div_en, running); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (digits !== 24'h000013) begin failures++; $display("FAIL pause_tick got=%h exp=000013", digits); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (digits !== 24'h000013 || div_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL pause_ignore got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_wrap();
    int bad;
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < PERIOD_T - 1; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (digits !== e_digits || ovf !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_climb got=%0d bad cycles exp=0", bad); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (digits !== 24'h015999) begin failures++; $display("FAIL wrap_pre got=%h exp=015999", digits); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL wrap_ovf got=%b exp=1", ovf); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (ovf !== 1'b0 || digits !== 24'h0) begin failures++; $display("FAIL wrap_post got=%b/%h exp=0/000000", ovf, digits); end
    run_ticks(TPC);
    step(1'b0, 1'b0, 1'b0);
    checks++; if (digits !== 24'h000001) begin failures++; $display("FAIL wrap_continue got=%h exp=000001", digits); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    run_ticks(TPC * 4200);
    step(1'b1, 1'b0, 1'b0);
    checks++; if (digits !== 24'h004200) begin failures++; $display("FAIL pre_reset got=%h exp=004200", digits); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({digits, div_en, running, lap_active, ovf} !== 28'h0) begin failures++; $display("FAIL async_reset got=%h/%b%b%b%b exp=0", digits, div_en, running, lap_active, ovf); end
    reset = 1'b1;
    model_reset();
    run_ticks(5);
    step(1'b0, 1'b0, 1'b0);
    checks++; if (digits !== 24'h0 || running !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%h/%b exp=000000/0", digits, running); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(1, 0)), ($urandom_range(19, 0) == 0), ($urandom_range(14, 0) == 0));
      checks++;
      if (digits !== e_digits || ovf !== e_ovf || running !== e_run || div_en !== e_run || lap_active !== e_lap) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cyc=%0d got=%h %b%b%b%b exp=%h %b%b%b%b", i, digits, ovf, running, div_en, lap_active,
                   e_digits, e_ovf, e_run, e_run, e_lap);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_1s();
    test_lap();
    test_same_cycle();
    test_tick_pause();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
